// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_pkg
// Description : Shared core definitions for the IF/ID pipeline register:
//               instruction bus widths, the canonical NOP encoding and the
//               skid-buffer state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_pkg;

    // Instruction address / data bus widths
    localparam int c_INST_ADDR_W = 32;
    localparam int c_INST_DATA_W = 32;

    // addi x0, x0, 0 - the bubble presented to decode when nothing is live
    localparam logic [c_INST_DATA_W-1:0] c_NOP_INST = 32'h00000013;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // no entries held
        ST_ONE   = 2'd1,   // main register holds the only entry
        ST_FULL  = 2'd2    // main and skid registers both hold entries
    } if_id_state_e;

endpackage : if_id_pkg
`default_nettype wire

// File: rtl/if_id.sv
`default_nettype none
// ============================================================================
// Module      : if_id
// Description : IF/ID pipeline register implemented as a 2-entry skid buffer.
//               A main register drives decode; a skid register absorbs the
//               one entry that can arrive after decode stalls, so that the
//               ready signal back to fetch can be fully registered.
//
// Ports       : clk       - clock, all state updates on rising edge
//               rst       - synchronous active-high reset
//               if_pc     - PC of the fetched instruction
//               if_inst   - fetched instruction word
//               if_valid  - fetch offers if_pc/if_inst this cycle
//               id_ready  - buffer can accept this cycle (registered)
//               flush     - discard every held and incoming entry
//               id_pc     - PC presented to decode
//               id_inst   - instruction presented to decode (NOP when idle)
//               id_valid  - id_pc/id_inst hold a live entry
//               dec_ready - decode consumes the presented entry this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module if_id
    import if_id_pkg::*;
#(
    parameter logic [c_INST_DATA_W-1:0] NOP_INST = c_NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [c_INST_ADDR_W-1:0] if_pc,
    input  logic [c_INST_DATA_W-1:0] if_inst,
    input  logic                     if_valid,
    output logic                     id_ready,
    input  logic                     flush,
    output logic [c_INST_ADDR_W-1:0] id_pc,
    output logic [c_INST_DATA_W-1:0] id_inst,
    output logic                     id_valid,
    input  logic                     dec_ready
);

    if_id_state_e             r_state;
    if_id_state_e             w_state_nxt;
    logic                     r_ready;
    logic [c_INST_ADDR_W-1:0] r_main_pc;
    logic [c_INST_DATA_W-1:0] r_main_inst;
    logic [c_INST_ADDR_W-1:0] r_skid_pc;
    logic [c_INST_DATA_W-1:0] r_skid_inst;

    logic w_accept;
    logic w_take;
    logic w_valid;

    assign w_valid  = (r_state != ST_EMPTY);
    assign w_accept = if_valid && r_ready;
    assign w_take   = w_valid && dec_ready;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept)              w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_take)         w_state_nxt = ST_FULL;
                    else if (w_take && !w_accept)    w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_take)                w_state_nxt = ST_ONE;
                default:                             w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_ready     <= 1'b1;
            r_main_pc   <= '0;
            r_main_inst <= NOP_INST;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Ready is a pure function of the upcoming occupancy, so fetch
            // never sees a combinational path from dec_ready or if_valid.
            r_ready <= (w_state_nxt != ST_FULL);

            if (flush) begin
                // Main falls back to the bubble so id_inst reads NOP while idle
                r_main_inst <= NOP_INST;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_main_pc   <= if_pc;
                            r_main_inst <= if_inst;
                        end
                    end
                    ST_ONE: begin
                        if (w_accept && w_take) begin
                            r_main_pc   <= if_pc;
                            r_main_inst <= if_inst;
                        end else if (w_accept) begin
                            r_skid_pc   <= if_pc;
                            r_skid_inst <= if_inst;
                        end else if (w_take) begin
                            r_main_inst <= NOP_INST;
                        end
                    end
                    ST_FULL: begin
                        if (w_take) begin
                            r_main_pc   <= r_skid_pc;
                            r_main_inst <= r_skid_inst;
                        end
                    end
                    default: begin
                        r_main_inst <= NOP_INST;
                    end
                endcase
            end
        end
    end

    assign id_ready = r_ready;
    assign id_valid = w_valid;
    assign id_pc    = r_main_pc;
    assign id_inst  = r_main_inst;

endmodule : if_id
`default_nettype wire

// File: tb/tb_if_id.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id
// Description : Self-checking bench for if_id. A FIFO-occupancy reference
//               model (queue of at most two entries) predicts id_* and
//               id_ready each cycle; directed scenarios are followed by a
//               randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id;

    localparam logic [31:0] c_NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        id_ready;
    logic        flush;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        dec_ready;

    int n_checks;
    int n_errors;

    // Reference model: entries in acceptance order, {pc, inst}
    logic [63:0] mq[$];

    if_id dut (
        .clk       (clk),
        .rst       (rst),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .id_ready  (id_ready),
        .flush     (flush),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_valid  (id_valid),
        .dec_ready (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every visible output with the model's prediction
    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, mq.size() > 0});
        chk({tag, ".ready"}, {31'd0, id_ready}, {31'd0, mq.size() < 2});
        if (mq.size() > 0) begin
            chk({tag, ".pc"},   id_pc,   mq[0][63:32]);
            chk({tag, ".inst"}, id_inst, mq[0][31:0]);
        end else begin
            chk({tag, ".inst"}, id_inst, c_NOP);
        end
    endtask

    // One clock: apply inputs, advance the model by the queue rules, check
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] pc, input logic [31:0] inst,
                        input logic d, input string tag);
        bit acc;
        bit tk;
        rst = r; flush = f; if_valid = v; if_pc = pc; if_inst = inst; dec_ready = d;
        acc = v && (mq.size() < 2);
        tk  = d && (mq.size() > 0);
        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else begin
            if (tk)  void'(mq.pop_front());
            if (acc) mq.push_back({pc, inst});
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return {pc[15:0], 16'hA5B3};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; dec_ready = 1'b0;

        // Reset state
        step(1, 0, 0, 32'h0, 32'h0, 0, "reset");
        chk("reset.pc", id_pc, 32'h0);

        // Back-to-back stream with decode always ready
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 32'h80000000 + 32'(i * 4), mk_inst(32'h80000000 + 32'(i * 4)), 1, "stream");
            chk("stream.pc_now", id_pc, 32'h80000000 + 32'(i * 4));
        end
        step(0, 0, 0, 32'h0, 32'h0, 1, "stream_drain");

        // Stall: two entries arrive while decode is blocked
        step(0, 0, 1, 32'h80000000, mk_inst(32'h80000000), 0, "stall0");
        step(0, 0, 1, 32'h80000004, mk_inst(32'h80000004), 0, "stall1");
        chk("stall.full_ready", {31'd0, id_ready}, 32'd0);
        chk("stall.hold_pc", id_pc, 32'h80000000);
        // Offer while FULL and decode ready: refused, skid moves to main
        step(0, 0, 1, 32'h80000008, mk_inst(32'h80000008), 1, "full_take");
        chk("full_take.pc", id_pc, 32'h80000004);
        step(0, 0, 0, 32'h0, 32'h0, 1, "full_drain");

        // Flush while FULL with an incoming entry
        step(0, 0, 1, 32'h90000000, mk_inst(32'h90000000), 0, "pre_flush0");
        step(0, 0, 1, 32'h90000004, mk_inst(32'h90000004), 0, "pre_flush1");
        step(0, 1, 1, 32'h90000008, mk_inst(32'h90000008), 1, "flush");
        chk("flush.inst", id_inst, c_NOP);
        step(0, 0, 0, 32'h0, 32'h0, 1, "post_flush");

        // Reset arriving mid-stall in FULL
        step(0, 0, 1, 32'hA0000000, mk_inst(32'hA0000000), 0, "pre_rst0");
        step(0, 0, 1, 32'hA0000004, mk_inst(32'hA0000004), 0, "pre_rst1");
        step(1, 1, 1, 32'hA0000008, mk_inst(32'hA0000008), 1, "rst_mid");
        chk("rst_mid.pc", id_pc, 32'h0);
        step(0, 0, 1, 32'hB0000000, mk_inst(32'hB0000000), 0, "after_rst");
        chk("after_rst.pc", id_pc, 32'hB0000000);
        step(0, 0, 0, 32'h0, 32'h0, 1, "after_rst_drain");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = $urandom;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 99) < 70), pc, $urandom, ($urandom_range(0, 99) < 55),
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_if_id
`default_nettype wire

// File: doc/if_id.md
IF_ID -- requirements
Module: if_id

Interface
REQ-001 Parameter NOP_INST, default 32'h00000013, is the instruction presented on id_inst whenever id_valid is low.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 if_pc  input  32  PC of the fetched instruction (INST_ADDR_BUS).
REQ-005 if_inst  input  32  fetched instruction word (INST_DATA_BUS).
REQ-006 if_valid  input  1  fetch offers if_pc/if_inst this cycle.
REQ-007 id_ready  output  1  block can accept this cycle; drives the fetch stage's id_ready input.
REQ-008 flush  input  1  redirect from a later stage; discards every held and incoming entry.
REQ-009 id_pc  output  32  PC presented to decode.
REQ-010 id_inst  output  32  instruction presented to decode.
REQ-011 id_valid  output  1  id_pc/id_inst hold a live entry.
REQ-012 dec_ready  input  1  decode consumes the presented entry this cycle.

Function
REQ-013 The block SHALL be a 2-entry skid buffer: a main register driving id_*, plus one skid register.
REQ-014 accept = if_valid && id_ready; take = id_valid && dec_ready.
REQ-015 id_ready SHALL be a registered output, high exactly when state != FULL, with no combinational path from dec_ready or if_valid.
REQ-016 State machine states SHALL be EMPTY (0 entries), ONE (main only) and FULL (main + skid).
REQ-017 EMPTY: accept -> ONE, loading main.
REQ-018 ONE, accept && !take -> FULL, loading skid.
REQ-019 ONE, take && !accept -> EMPTY.
REQ-020 ONE, accept && take -> ONE, reloading main with the new entry.
REQ-021 ONE, neither accept nor take -> ONE, holding main.
REQ-022 FULL: take -> ONE, skid moves into main.
REQ-023 FULL: no take -> FULL, holding both registers.
REQ-024 An entry accepted in cycle N SHALL appear on id_* in cycle N+1 when the buffer was EMPTY, or when it was ONE with take.
REQ-025 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated, except by flush.
REQ-026 While id_valid && !dec_ready, id_pc and id_inst SHALL hold stable.
REQ-027 id_valid SHALL equal (state != EMPTY).
REQ-028 id_inst SHALL equal NOP_INST whenever id_valid is low.
REQ-029 flush SHALL force EMPTY on the next edge, overriding a simultaneous accept or take; the next cycle shows id_valid=0 and id_ready=1.

Reset
REQ-030 While rst is high at a rising edge, the block SHALL enter EMPTY.
REQ-031 Reset values: id_valid=0, id_ready=1, id_pc=32'h0, id_inst=NOP_INST, skid register cleared.
REQ-032 Reset SHALL take priority over flush, accept and take, including when it arrives mid-stall in FULL.

Structure
REQ-033 The state enum typedef SHALL live in the shared core package; bus widths and the NOP encoding SHALL come from the shared defines header.
REQ-034 The block SHALL have no sub-modules: a single always_ff for state and data, and a single always_comb for next-state.

Verification
REQ-035 Stream: four back-to-back entries (pc 0x80000000, +4, +8, +C) with dec_ready=1 -> each appears on id_* one cycle later, in order; id_ready stays 1.
REQ-036 Stall: dec_ready=0 while entries 0x80000000 and 0x80000004 arrive -> FULL; id_ready=0 in the next cycle; id_pc holds 0x80000000. Then dec_ready=1 -> 0x80000004 appears the following cycle.
REQ-037 Simultaneous in FULL: dec_ready=1 with if_valid=1 -> the input is not accepted (id_ready=0); the state goes to ONE with the skid entry in main.
REQ-038 Flush in FULL with if_valid=1 -> next cycle id_valid=0, id_inst=32'h00000013, id_ready=1; neither held entry ever appears on id_*.
REQ-039 Reset asserted mid-stall (FULL) -> next cycle shows all REQ-031 values; the first entry after reset appears on id_* one cycle after it is accepted.
